// File: rtl/regwrite_queue_pkg.sv
// -----------------------------------------------------------------------------
// regwrite_queue_pkg
// Shared definitions for the register write-back queue: architectural register
// index/data widths, the queued write-back entry type and a helper that sizes
// the occupancy counter for a given queue depth.
// No ports (package).
// -----------------------------------------------------------------------------
package regwrite_queue_pkg;

    localparam int REG_AW = 5;   // 32 architectural registers
    localparam int REG_DW = 32;  // register data width

    // One queued register write-back.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    // Counter width able to hold 0..depth inclusive (depth is a power of two).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/regwrite_queue_if.sv
// -----------------------------------------------------------------------------
// regwrite_queue_if
// Bundles the producer handshakes, the regfile write port and the decode
// hazard-query port of the register write-back queue.
//
// Handshake semantics (both producers): a transfer happens on the rising edge
// where valid and ready are both 1. ready depends only on registered queue
// state, never on valid in the same cycle; a producer may hold valid with
// stable reg/data until it sees ready.
//
// Signals:
//   in_a_valid/ready/reg/data  producer A (main pipeline writeback, older)
//   in_b_valid/ready/reg/data  producer B (mult/div unit)
//   wb_we/wb_reg/wb_data       regfile write port (head of queue)
//   q_reg_a/b                  hazard query register indices
//   q_pend_a/b                 a queued write targets q_reg_a/b
//   q_data_a/b                 forwarded data (zero when forwarding is off)
// Modports:
//   master  producers + decode + regfile side
//   slave   the queue itself
// -----------------------------------------------------------------------------
interface regwrite_queue_if
    import regwrite_queue_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
);
    logic          in_a_valid;
    logic          in_a_ready;
    logic [AW-1:0] in_a_reg;
    logic [DW-1:0] in_a_data;
    logic          in_b_valid;
    logic          in_b_ready;
    logic [AW-1:0] in_b_reg;
    logic [DW-1:0] in_b_data;
    logic          wb_we;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] q_reg_a;
    logic [AW-1:0] q_reg_b;
    logic          q_pend_a;
    logic          q_pend_b;
    logic [DW-1:0] q_data_a;
    logic [DW-1:0] q_data_b;

    modport master (
        output in_a_valid, in_a_reg, in_a_data,
        output in_b_valid, in_b_reg, in_b_data,
        output q_reg_a, q_reg_b,
        input  in_a_ready, in_b_ready,
        input  wb_we, wb_reg, wb_data,
        input  q_pend_a, q_pend_b, q_data_a, q_data_b
    );

    modport slave (
        input  in_a_valid, in_a_reg, in_a_data,
        input  in_b_valid, in_b_reg, in_b_data,
        input  q_reg_a, q_reg_b,
        output in_a_ready, in_b_ready,
        output wb_we, wb_reg, wb_data,
        output q_pend_a, q_pend_b, q_data_a, q_data_b
    );

endinterface

// File: rtl/regwrite_queue_wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// DEPTH-entry circular buffer with two push ports (A written before B, so A is
// older) and one pop port per cycle. Exposes the raw storage, head pointer,
// entry count and a per-slot valid vector so the parent can run the register
// CAM and read the head directly.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_push_a/reg/data    push port A (older of the two)
//   i_push_b/reg/data    push port B
//   i_pop                drop the head entry (only when count != 0)
//   o_count              current entry count, 0..DEPTH
//   o_head               slot index of the oldest entry
//   o_ent_reg/data       storage contents per slot
//   o_ent_valid          slot currently holds a queued entry
// The parent guarantees pushes never exceed free space and pop only when
// non-empty.
// -----------------------------------------------------------------------------
module wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push_a,
    input  logic [AW-1:0]            i_reg_a,
    input  logic [DW-1:0]            i_data_a,
    input  logic                     i_push_b,
    input  logic [AW-1:0]            i_reg_b,
    input  logic [DW-1:0]            i_data_b,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH)-1:0] o_head,
    output logic [AW-1:0]            o_ent_reg  [DEPTH],
    output logic [DW-1:0]            o_ent_data [DEPTH],
    output logic [DEPTH-1:0]         o_ent_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_reg  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_b_slot;

    // B lands behind A when both push in the same cycle.
    assign w_b_slot = r_tail + PW'(i_push_a);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_push_a) begin
                r_reg[r_tail]  <= i_reg_a;
                r_data[r_tail] <= i_data_a;
            end
            if (i_push_b) begin
                r_reg[w_b_slot]  <= i_reg_b;
                r_data[w_b_slot] <= i_data_b;
            end
            // Pointers are DEPTH-modulo by width (DEPTH is a power of two).
            r_tail  <= r_tail + PW'(i_push_a) + PW'(i_push_b);
            r_head  <= r_head + PW'(i_pop);
            r_count <= r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(i_pop);
        end
    end

    // A slot is live when its distance from head is below the count.
    always_comb begin
        o_ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_valid[i] = ({1'b0, PW'(PW'(i) - r_head)} < r_count);
        end
    end

    assign o_count    = r_count;
    assign o_head     = r_head;
    assign o_ent_reg  = r_reg;
    assign o_ent_data = r_data;

endmodule

// File: rtl/regwrite_queue.sv
// -----------------------------------------------------------------------------
// regwrite_queue
// Write-side initiator for the register file. Buffers write-backs from the
// main pipeline (A) and the mult/div unit (B), drains one per cycle onto the
// regfile write port and answers decode hazard queries.
//
// Ports:
//   clock         single clock, all state on the rising edge
//   ctrl_reset_n  synchronous active-low reset (discards queued writes)
//   bus           regwrite_queue_if.slave: producer handshakes, regfile write
//                 port, hazard query/forward port
//   occupancy     current entry count (debug/LED)
//
// Optional feature: define REGWRITE_QUEUE_FWD_EN to forward the data of the
// youngest queued write to each queried register on q_data_a/b. Without it
// q_data_a/b are tied to zero and only q_pend_a/b are produced.
// -----------------------------------------------------------------------------
module regwrite_queue
    import regwrite_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    regwrite_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0]    w_count;
    logic [PW-1:0]    w_head;
    logic [AW-1:0]    w_ent_reg  [DEPTH];
    logic [DW-1:0]    w_ent_data [DEPTH];
    logic [DEPTH-1:0] w_ent_valid;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop;
    logic             w_pend_a;
    logic             w_pend_b;

    // Readies come from the registered count only. B needs room for two
    // because A may take a slot in the same cycle.
    assign w_a_ready = (w_count <= CW'(DEPTH - 1));
    assign w_b_ready = (w_count <= CW'(DEPTH - 2));

    // r0 writes complete the handshake but are dropped (r0 is hardwired zero).
    assign w_push_a = bus.in_a_valid & w_a_ready & (bus.in_a_reg != '0);
    assign w_push_b = bus.in_b_valid & w_b_ready & (bus.in_b_reg != '0);

    // The regfile always takes the head, so drain never stalls.
    assign w_pop = (w_count != '0);

    wbq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (ctrl_reset_n),
        .i_push_a    (w_push_a),
        .i_reg_a     (bus.in_a_reg),
        .i_data_a    (bus.in_a_data),
        .i_push_b    (w_push_b),
        .i_reg_b     (bus.in_b_reg),
        .i_data_b    (bus.in_b_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_ent_reg   (w_ent_reg),
        .o_ent_data  (w_ent_data),
        .o_ent_valid (w_ent_valid)
    );

    assign bus.in_a_ready = w_a_ready;
    assign bus.in_b_ready = w_b_ready;
    assign bus.wb_we      = w_pop;
    assign bus.wb_reg     = w_pop ? w_ent_reg[w_head]  : '0;
    assign bus.wb_data    = w_pop ? w_ent_data[w_head] : '0;
    assign occupancy      = w_count;

    // Hazard CAM over every live entry, the head included: the head is still
    // pending during the cycle its regfile write is presented.
    always_comb begin
        w_pend_a = 1'b0;
        w_pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && (w_ent_reg[i] == bus.q_reg_a)) w_pend_a = 1'b1;
            if (w_ent_valid[i] && (w_ent_reg[i] == bus.q_reg_b)) w_pend_b = 1'b1;
        end
    end

    assign bus.q_pend_a = w_pend_a & (bus.q_reg_a != '0);
    assign bus.q_pend_b = w_pend_b & (bus.q_reg_b != '0);

`ifdef REGWRITE_QUEUE_FWD_EN
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    // Slot holding the k-th oldest entry.
    function automatic logic [PW-1:0] age_slot(input logic [PW-1:0] head, input int k);
        return head + PW'(k);
    endfunction

    // Walk oldest to youngest so a later match overrides: youngest wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_ent_valid[age_slot(w_head, k)] &&
                (w_ent_reg[age_slot(w_head, k)] == bus.q_reg_a))
                w_fwd_a = w_ent_data[age_slot(w_head, k)];
            if (w_ent_valid[age_slot(w_head, k)] &&
                (w_ent_reg[age_slot(w_head, k)] == bus.q_reg_b))
                w_fwd_b = w_ent_data[age_slot(w_head, k)];
        end
    end

    assign bus.q_data_a = (bus.q_reg_a != '0) ? w_fwd_a : '0;
    assign bus.q_data_b = (bus.q_reg_b != '0) ? w_fwd_b : '0;
`else
    assign bus.q_data_a = '0;
    assign bus.q_data_b = '0;
`endif

endmodule

// File: tb/tb_regwrite_queue.sv
// -----------------------------------------------------------------------------
// tb_regwrite_queue
// Self-checking bench for regwrite_queue. A queue of {reg,data} entries models
// the write-back buffer; every cycle the DUT outputs are compared against what
// that queue implies. Directed sequences pin literal values, then randomized
// traffic (with occasional resets) runs against the model.
// -----------------------------------------------------------------------------
module tb_regwrite_queue;
    import regwrite_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = REG_AW;
    localparam int DW    = REG_DW;
    localparam int W     = $bits(wb_entry_t);
`ifdef REGWRITE_QUEUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    always #5 clock = ~clock;

    regwrite_queue_if #(.AW(AW), .DW(DW)) bus();

    regwrite_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus.slave),
        .occupancy    (occupancy)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    // Model: queued writes, oldest first.
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit av, input int ar, input logic [DW-1:0] ad,
                         input bit bv, input int br, input logic [DW-1:0] bd);
        bus.in_a_valid = av;
        bus.in_a_reg   = AW'(ar);
        bus.in_a_data  = ad;
        bus.in_b_valid = bv;
        bus.in_b_reg   = AW'(br);
        bus.in_b_data  = bd;
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic query(input int qa, input int qb);
        bus.q_reg_a = AW'(qa);
        bus.q_reg_b = AW'(qb);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- model update (one edge) ----------------
    always @(posedge clock) begin : model_update
        int sz;
        bit ra, rb;
        if (!ctrl_reset_n) begin
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            ra = (sz <= DEPTH - 1);
            rb = (sz <= DEPTH - 2);
            if (sz != 0) void'(exp_q.pop_front());
            if (bus.in_a_valid && ra && bus.in_a_reg != 0) exp_q.push_back({bus.in_a_reg, bus.in_a_data});
            if (bus.in_b_valid && rb && bus.in_b_reg != 0) exp_q.push_back({bus.in_b_reg, bus.in_b_data});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin : compare
        int sz;
        bit pa, pb;
        logic [DW-1:0] fa, fb;
        logic [AW-1:0] er;
        if (mon_en) begin
            sz = exp_q.size();
            pa = 1'b0; pb = 1'b0; fa = '0; fb = '0;
            for (int i = 0; i < sz; i++) begin
                er = exp_q[i][W-1:DW];
                if (bus.q_reg_a != 0 && er == bus.q_reg_a) begin pa = 1'b1; fa = exp_q[i][DW-1:0]; end
                if (bus.q_reg_b != 0 && er == bus.q_reg_b) begin pb = 1'b1; fb = exp_q[i][DW-1:0]; end
            end
            check("in_a_ready", bus.in_a_ready, (sz <= DEPTH - 1));
            check("in_b_ready", bus.in_b_ready, (sz <= DEPTH - 2));
            check("occupancy",  occupancy,     sz);
            check("wb_we",      bus.wb_we,     (sz != 0));
            check("wb_reg",     bus.wb_reg,    (sz != 0) ? exp_q[0][W-1:DW] : '0);
            check("wb_data",    bus.wb_data,   (sz != 0) ? exp_q[0][DW-1:0] : '0);
            check("q_pend_a",   bus.q_pend_a,  pa);
            check("q_pend_b",   bus.q_pend_b,  pb);
            check("q_data_a",   bus.q_data_a,  FWD ? fa : '0);
            check("q_data_b",   bus.q_data_b,  FWD ? fb : '0);
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        // Reset held with both producers valid.
        drive(1'b1, 9, 32'h1234_5678, 1'b1, 10, 32'h9abc_def0);
        query(9, 10);
        @(posedge clock);
        #1 mon_en = 1'b1;
        step();
        @(negedge clock);
        check("rst_occupancy", occupancy, 0);
        check("rst_wb_we", bus.wb_we, 0);
        check("rst_pend", bus.q_pend_a, 0);
        idle();
        step();
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        check("rst_a_ready", bus.in_a_ready, 1);
        check("rst_b_ready", bus.in_b_ready, 1);

        // Single A write r5.
        query(5, 0);
        drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, '0);
        step();
        idle();
        @(negedge clock);
        check("r5_we", bus.wb_we, 1);
        check("r5_reg", bus.wb_reg, 5);
        check("r5_data", bus.wb_data, 32'hDEAD_BEEF);
        check("r5_pend", bus.q_pend_a, 1);
        step();
        @(negedge clock);
        check("r5_we_after", bus.wb_we, 0);
        check("r5_pend_after", bus.q_pend_a, 0);

        // A r3 + B r4 same cycle: A drains first.
        drive(1'b1, 3, 32'h11, 1'b1, 4, 32'h22);
        step();
        idle();
        @(negedge clock);
        check("ab_first_reg", bus.wb_reg, 3);
        check("ab_first_data", bus.wb_data, 32'h11);
        step();
        @(negedge clock);
        check("ab_second_reg", bus.wb_reg, 4);
        check("ab_second_data", bus.wb_data, 32'h22);
        step();

        // Fill: A+B every cycle -> count settles at DEPTH-1 with B throttled.
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1 + (c % 7), 32'hA000 + c, 1'b1, 8 + (c % 7), 32'hB000 + c);
            step();
        end
        @(negedge clock);
        check("fill_occupancy", occupancy, DEPTH - 1);
        check("fill_b_ready", bus.in_b_ready, 0);
        check("fill_a_ready", bus.in_a_ready, 1);
        idle();
        repeat (DEPTH) step();
        @(negedge clock);
        check("fill_drained", occupancy, 0);

        // Write to r0 is accepted but dropped.
        drive(1'b1, 0, 32'h55, 1'b0, 0, '0);
        @(negedge clock);
        check("r0_ready", bus.in_a_ready, 1);
        step();
        idle();
        @(negedge clock);
        check("r0_we", bus.wb_we, 0);
        check("r0_occupancy", occupancy, 0);

        // Two writes to r7: youngest data forwarded.
        query(7, 7);
        drive(1'b1, 7, 32'h1, 1'b1, 7, 32'h2);
        step();
        idle();
        @(negedge clock);
        check("r7_pend", bus.q_pend_a, 1);
        check("r7_data", bus.q_data_a, FWD ? 32'h2 : 32'h0);
        step();
        @(negedge clock);
        check("r7_pend_pop", bus.q_pend_b, 1);
        check("r7_data_pop", bus.q_data_b, FWD ? 32'h2 : 32'h0);
        step();

        // Reset with 3 entries queued discards them.
        drive(1'b1, 12, 32'hC1, 1'b1, 13, 32'hC2);
        step();
        drive(1'b1, 14, 32'hC3, 1'b1, 15, 32'hC4);
        step();
        idle();
        @(negedge clock);
        check("pre_rst_occupancy", occupancy, 3);
        ctrl_reset_n = 1'b0;
        step();
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_we", bus.wb_we, 0);
        check("mid_rst_occupancy", occupancy, 0);
        repeat (3) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            ctrl_reset_n = ($urandom_range(0, 80) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom);
            query($urandom_range(0, 7), $urandom_range(0, 7));
            step();
        end
        ctrl_reset_n = 1'b1;
        idle();
        repeat (DEPTH + 2) step();
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
